// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, fixed-latency line fill on a miss.
// Optional INSCACHE_FILL_FORWARD_EN forwards imem_in to the output in the last wait cycle of a matching fill.
module ins_cache #(
    parameter int NUM_LINES    = 16,
    parameter int MISS_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [31:0]  iaddr,
    input  logic [127:0] imem_in,
    output logic         ohit,
    output logic [31:0]  oins
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;
    localparam int CNT_W = $clog2(MISS_LATENCY + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0]     fill_tag_q, fill_tag_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;

    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [127:0]         data_mem [NUM_LINES];

    logic [IDX_W-1:0]     a_idx;
    logic [TAG_W-1:0]     a_tag;
    logic [1:0]           a_off;
    logic                 unused_addr_bits;
    logic                 arr_hit;
    logic                 last_wait;
    logic                 fill_we;
    logic                 fwd_hit;
    logic [127:0]         line_sel;
    logic [31:0]          arr_word;
    logic [31:0]          fwd_word;

    assign a_idx            = iaddr[3+IDX_W:4];
    assign a_tag            = iaddr[31:4+IDX_W];
    assign a_off            = iaddr[3:2];
    assign unused_addr_bits = ^iaddr[1:0];

    assign arr_hit   = valid_q[a_idx] && (tag_mem[a_idx] == a_tag);
    assign last_wait = (state_q == S_WAIT) && (cnt_q == CNT_W'(MISS_LATENCY - 1));
    assign fill_we   = last_wait && !rstn;

    assign line_sel  = data_mem[a_idx];
    assign arr_word  = line_sel[32*a_off +: 32];

`ifdef INSCACHE_FILL_FORWARD_EN
    assign fwd_hit  = last_wait && (a_idx == fill_idx_q) && (a_tag == fill_tag_q);
    assign fwd_word = imem_in[32*a_off +: 32];
`else
    assign fwd_hit  = 1'b0;
    assign fwd_word = 32'h0;
`endif

    // Array hit takes priority; forwarding only matters for a line not yet written.
    always_comb begin
        ohit = 1'b0;
        oins = 32'h0;
        if (!rstn) begin
            if (arr_hit) begin
                ohit = 1'b1;
                oins = arr_word;
            end else if (fwd_hit) begin
                ohit = 1'b1;
                oins = fwd_word;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_idx_d = fill_idx_q;
        fill_tag_d = fill_tag_q;
        valid_d    = valid_q;
        case (state_q)
            S_IDLE: begin
                if (!arr_hit) begin
                    fill_idx_d = a_idx;
                    fill_tag_d = a_tag;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
            end
            default: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last_wait) begin
                    valid_d[fill_idx_q] = 1'b1;
                    cnt_d               = '0;
                    state_d             = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx_q]  <= fill_tag_q;
            data_mem[fill_idx_q] <= imem_in;
        end
    end
endmodule

// File: tb/tb_ins_cache.sv
// Directed bench for ins_cache (NUM_LINES=16, MISS_LATENCY=4); expectations follow INSCACHE_FILL_FORWARD_EN.
module tb_ins_cache;
    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  iaddr;
    logic [127:0] imem_in;
    logic         ohit;
    logic [31:0]  oins;

    int total = 0;
    int bad   = 0;

`ifdef INSCACHE_FILL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    ins_cache #(.NUM_LINES(16), .MISS_LATENCY(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .iaddr   (iaddr),
        .imem_in (imem_in),
        .ohit    (ohit),
        .oins    (oins)
    );

    always #25 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] a, input string tag, input logic h, input logic [31:0] w);
        iaddr = a;
        #1;
        chk({tag, "_hit"}, {31'h0, ohit}, {31'h0, h});
        chk({tag, "_ins"}, oins, w);
    endtask

    initial begin
        rstn    = 1'b1;
        iaddr   = 32'h0000_0123;
        imem_in = '0;
        #10;
        chk("rst_hit", {31'h0, ohit}, 32'h0);
        chk("rst_ins", oins, 32'h0);
        tick();
        chk("rst_hit_edge", {31'h0, ohit}, 32'h0);

        // First fill: index 0, tag 0
        rstn    = 1'b0;
        imem_in = {32'hDEADBEEF, 32'hABABABAB, 32'hCDCDCDCD, 32'hEFEFEFEF};
        look(32'h7, "cold", 1'b0, 32'h0);
        tick();
        tick();
        chk("w1_hit", {31'h0, ohit}, 32'h0);
        tick();
        chk("w2_hit", {31'h0, ohit}, 32'h0);
        tick();
        chk("w3_hit", {31'h0, ohit}, {31'h0, FWD});
        chk("w3_ins", oins, FWD ? 32'hCDCDCDCD : 32'h0);
        tick();
        chk("fill_hit", {31'h0, ohit}, 32'h1);
        chk("fill_ins", oins, 32'hCDCDCDCD);

        look(32'h0, "w0", 1'b1, 32'hEFEFEFEF);
        look(32'h4, "w1", 1'b1, 32'hCDCDCDCD);
        look(32'h8, "w2", 1'b1, 32'hABABABAB);
        look(32'hC, "w3", 1'b1, 32'hDEADBEEF);

        // Index 1 fill; other line served during the wait
        imem_in = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        look(32'h10, "i1_miss", 1'b0, 32'h0);
        tick();
        look(32'h0, "i1_wait_other", 1'b1, 32'hEFEFEFEF);
        for (int i = 0; i < 4; i++) tick();
        look(32'h10, "i1_w0", 1'b1, 32'h44444444);
        look(32'h1C, "i1_w3", 1'b1, 32'h11111111);

        // Conflict eviction of index 0
        imem_in = {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        look(32'h100, "ev_miss", 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        look(32'h100, "ev_w0", 1'b1, 32'hD3D3D3D3);
        look(32'h108, "ev_w2", 1'b1, 32'hB1B1B1B1);
        look(32'h0, "ev_old", 1'b0, 32'h0);
        look(32'h10, "ev_keep", 1'b1, 32'h44444444);

        // Reset during the final wait cycle aborts the fill
        imem_in = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        look(32'h20, "ab_miss", 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("ab_fwd_hit", {31'h0, ohit}, {31'h0, FWD});
        chk("ab_fwd_ins", oins, FWD ? 32'h88888888 : 32'h0);
        rstn = 1'b1;
        #1;
        chk("ab_rst_hit", {31'h0, ohit}, 32'h0);
        tick();
        rstn = 1'b0;
        look(32'h20, "ab_line", 1'b0, 32'h0);
        look(32'h10, "ab_inv1", 1'b0, 32'h0);
        look(32'h100, "ab_inv0", 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
